// File: rtl/sprite_pkg.sv
// sprite_pkg: shared encodings, per-state frame tables and input bit positions for sprite animation
package sprite_pkg;
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WALK  = 3'd1,
        S_PUNCH = 3'd2,
        S_KICK  = 3'd3,
        S_BLOCK = 3'd4,
        S_HIT   = 3'd5
    } anim_state_t;

    localparam int LEFT  = 0;
    localparam int RIGHT = 1;
    localparam int BLOCK = 2;
    localparam int PUNCH = 3;
    localparam int KICK  = 4;

    localparam int SPRITE_WIDTH    = 128;
    localparam int SPRITE_HEIGHT   = 128;
    localparam int FRAMES_PER_PAGE = 16384;

    function automatic logic [3:0] state_base(anim_state_t s);
        return s == S_WALK  ? 4'd2  :
               s == S_PUNCH ? 4'd6  :
               s == S_KICK  ? 4'd9  :
               s == S_BLOCK ? 4'd13 :
               s == S_HIT   ? 4'd14 : 4'd0;
    endfunction

    function automatic logic [1:0] state_last(anim_state_t s);
        return s == S_WALK  ? 2'd3 :
               s == S_PUNCH ? 2'd2 :
               s == S_KICK  ? 2'd3 :
               s == S_BLOCK ? 2'd0 : 2'd1;
    endfunction

    function automatic logic is_one_shot(anim_state_t s);
        return s == S_PUNCH || s == S_KICK || s == S_HIT;
    endfunction
endpackage

// File: rtl/frame_tick_gen.sv
// frame_tick_gen: one-cycle tick per screen frame from a registered vblank-line compare with edge detect
module frame_tick_gen #(
    parameter int V_BLANK_LINE = 480
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic [9:0] vCount,
    output logic       tick
);
    logic match_q;
    logic at_line;
    assign at_line = vCount == 10'(V_BLANK_LINE);
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            match_q <= 1'b0;
            tick    <= 1'b0;
        end else begin
            match_q <= at_line;
            tick    <= at_line & ~match_q;
        end
    end
endmodule

// File: rtl/sprite_anim_sequencer.sv
// sprite_anim_sequencer: vblank-synchronous animation state and sprite page select for one player
module sprite_anim_sequencer
    import sprite_pkg::*;
#(
    parameter int V_BLANK_LINE = 480,
    parameter int HOLD_TICKS   = 4,
    parameter int PUNCH_ACTIVE = 1,
    parameter int KICK_ACTIVE  = 2
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic [9:0] vCount,
    input  logic [6:0] player_inputs,
    input  logic [3:0] shield,
    input  logic       hit_pulse,
    output logic [2:0] anim_state,
    output logic [3:0] frame_sel,
    output logic       attack_active,
    output logic       busy
);
    anim_state_t state, state_n, decision, target;
    logic [1:0] frame_idx, frame_n;
    logic [3:0] hold, hold_n, frame_sel_n;
    logic pend_hit, pend_punch, pend_kick, prev_punch, prev_kick;
    logic pend_hit_n, pend_punch_n, pend_kick_n, attack_n, busy_n;
    logic tick, eff_hit, eff_punch, eff_kick, wrap, done, run, restart, consume;
    logic unused_reserved;

    assign unused_reserved = &{1'b0, player_inputs[6:5]};
    assign anim_state = state;

    frame_tick_gen #(.V_BLANK_LINE(V_BLANK_LINE)) u_tick (
        .clk(clk),
        .rst_l(rst_l),
        .vCount(vCount),
        .tick(tick)
    );

    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state         <= S_IDLE;
            frame_idx     <= 2'd0;
            hold          <= 4'd0;
            pend_hit      <= 1'b0;
            pend_punch    <= 1'b0;
            pend_kick     <= 1'b0;
            prev_punch    <= 1'b0;
            prev_kick     <= 1'b0;
            frame_sel     <= 4'd0;
            attack_active <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_n;
            frame_idx     <= frame_n;
            hold          <= hold_n;
            pend_hit      <= pend_hit_n;
            pend_punch    <= pend_punch_n;
            pend_kick     <= pend_kick_n;
            prev_punch    <= player_inputs[PUNCH];
            prev_kick     <= player_inputs[KICK];
            frame_sel     <= frame_sel_n;
            attack_active <= attack_n;
            busy          <= busy_n;
        end
    end

    // presses arriving on the tick cycle itself are folded in before the decision
    always_comb begin
        eff_hit      = pend_hit | hit_pulse;
        eff_punch    = pend_punch | (player_inputs[PUNCH] & ~prev_punch);
        eff_kick     = pend_kick | (player_inputs[KICK] & ~prev_kick);
        decision     = eff_hit ? S_HIT : eff_punch ? S_PUNCH : eff_kick ? S_KICK :
                       (player_inputs[BLOCK] && shield != 4'd0) ? S_BLOCK :
                       (player_inputs[LEFT] ^ player_inputs[RIGHT]) ? S_WALK : S_IDLE;
        wrap         = hold == 4'(HOLD_TICKS - 1);
        done         = is_one_shot(state) && wrap && frame_idx == state_last(state);
        run          = !is_one_shot(state) || done;
        consume      = run || eff_hit;
        target       = consume ? decision : state;
        restart      = eff_hit || done || target != state;
        state_n      = tick ? target : state;
        frame_n      = !tick ? frame_idx : restart ? 2'd0 :
                       !wrap ? frame_idx : frame_idx == state_last(state) ? 2'd0 : frame_idx + 2'd1;
        hold_n       = !tick ? hold : (restart || wrap) ? 4'd0 : hold + 4'd1;
        pend_hit_n   = tick ? 1'b0 : eff_hit;
        pend_punch_n = (tick && consume) ? 1'b0 : eff_punch;
        pend_kick_n  = (tick && consume) ? 1'b0 : eff_kick;
    end

    always_comb begin
        frame_sel_n = state_base(state_n) + {2'b00, frame_n};
        attack_n    = (state_n == S_PUNCH && frame_n == 2'(PUNCH_ACTIVE)) ||
                      (state_n == S_KICK && frame_n == 2'(KICK_ACTIVE));
        busy_n      = is_one_shot(state_n);
    end
endmodule

// File: doc/sprite_anim_sequencer.md
Name: sprite_anim_sequencer

Overview:
- Per-player animation controller that sequences the 128x128 sprite ROM.
- Turns the 7-bit player input vector and game hit events into an animation state, and from that a 4-bit sprite frame select.
- The renderer uses the frame select to pick the ROM page it reads.
- Updates only at vertical-blank boundaries so a frame never tears mid-scan.
- One instance per player, between the input/game logic and the sprite ROM/renderer.

Parameters:
- V_BLANK_LINE, 480: vCount value that marks the start of vertical blank (the frame tick source).
- HOLD_TICKS, 4: screen frames each animation frame is held; range 1..15.
- PUNCH_ACTIVE, 1: PUNCH frame index on which attack_active is asserted.
- KICK_ACTIVE, 2: KICK frame index on which attack_active is asserted.

Ports:
- clk  in  1  system clock
- rst_l  in  1  asynchronous, active-low reset
- vCount  in  10  current VGA line
- player_inputs  in  7  [0] left, [1] right, [2] block, [3] punch, [4] kick, [6:5] reserved
- shield  in  4  current shield level; blocking is allowed only when nonzero
- hit_pulse  in  1  one-cycle pulse from game logic when this player takes damage
- anim_state  out  3  0 IDLE, 1 WALK, 2 PUNCH, 3 KICK, 4 BLOCK, 5 HIT
- frame_sel  out  4  sprite ROM page (ROM address = frame_sel*16384 + sprite_addr)
- attack_active  out  1  hitbox live this screen frame
- busy  out  1  high in PUNCH, KICK or HIT (non-interruptible except by HIT)

Behaviour:
- Reset (asynchronous, any time including mid-animation): state IDLE, frame_idx 0, hold counter 0, pending flags 0. Outputs: anim_state 0, frame_sel 0, attack_active 0, busy 0.
- Frame tick: one-cycle pulse on the first clk where vCount == V_BLANK_LINE after a cycle where it was not. This is a registered compare with edge detect, so exactly one tick per screen frame.
- Press latching:
  - A rising edge on punch or kick sets pend_punch / pend_kick; a hit_pulse sets pend_hit.
  - All pending flags are sampled and cleared on the tick on which they are consumed.
  - Entering HIT clears pend_punch and pend_kick.
  - A press and a tick in the same cycle counts for that tick.
- Hold counter: counts ticks 0..HOLD_TICKS-1. frame_idx advances when the counter wraps, then the counter restarts at 0. Any state change resets frame_idx and the hold counter to 0.
- Decision priority, evaluated on a tick in IDLE, WALK or BLOCK, or at the end of a one-shot:
  - pend_hit → HIT
  - else pend_punch → PUNCH
  - else pend_kick → KICK
  - else block && shield != 0 → BLOCK
  - else left XOR right → WALK
  - else IDLE
- States and frame counts:
  - IDLE: 2 frames, looping.
  - WALK: 4 frames, looping.
  - BLOCK: 1 frame, held while the decision still yields BLOCK.
  - PUNCH: 3 frames, one-shot.
  - KICK: 4 frames, one-shot.
  - HIT: 2 frames, one-shot.
  - A one-shot ends on the tick where the last frame's hold completes; that same tick runs the decision.
- Preemption:
  - pend_hit on any tick preempts any state, including HIT itself, which restarts at frame 0.
  - PUNCH and KICK otherwise ignore inputs until they complete.
- frame_sel = state base + frame_idx, 4-bit. Bases: IDLE 0, WALK 2, PUNCH 6, KICK 9, BLOCK 13, HIT 14. frame_sel never exceeds 15.
- attack_active = (PUNCH && frame_idx == PUNCH_ACTIVE) || (KICK && frame_idx == KICK_ACTIVE).
- Output timing: all outputs are registered and change only on the cycle after a tick, never during active video.
- Reserved input bits have no effect.

Decomposition:
- Shared package sprite_pkg holds:
  - state encodings
  - per-state base and length constants
  - input bit index constants (LEFT, RIGHT, BLOCK, PUNCH, KICK)
  - SPRITE_WIDTH, SPRITE_HEIGHT = 128
  - FRAMES_PER_PAGE = 16384
- One natural sub-module: frame_tick_gen (vCount compare plus edge detect → tick), reused by other vblank-synchronous logic.

Test Plan:
- Reset, no inputs, HOLD_TICKS=4, 16 ticks → frame_sel sequence 0,0,0,0,1,1,1,1,0,… with anim_state 0.
- Hold right → at the next tick anim_state 1, frame_sel steps 2,3,4,5,2 every 4 ticks. Press left as well → IDLE at the next tick.
- Single-cycle punch pulse mid-frame → PUNCH at the next tick, frame_sel 6,7,8, attack_active high only during frame 7's 4 ticks, busy high for 12 ticks, then IDLE.
- hit_pulse at KICK frame_idx 1 → next tick anim_state 5, frame_sel 14, attack_active 0, pending kick cleared. A second hit_pulse at HIT frame 15 → restart at 14.
- Hold block with shield=0 → IDLE. Raise shield to 3 → BLOCK, frame_sel 13 held. Release → IDLE.
- Deassert rst_l during PUNCH frame 7, asynchronous to clk → all outputs 0 immediately. After release, the first tick yields IDLE with frame_sel 0.
